tc_tile_sequencer: RTL and testbench

//  Initiator/feeder for the 4x8x4 FP8 tensorcore. Accepts a job (K step count, format, C-init mode),

---
 rtl/tc_tile_sequencer.sv | 164 ++++++++++++++++
 tb/tb_tc_tile_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_tile_sequencer.sv
// Job sequencer for the 4x8x4 FP8 tensorcore: packs 64-bit operand beats into 256-bit A/B/C words,
// issues one op per K step with D fed back as the next C, then streams the final tile out in 64-bit beats.
module tc_tile_sequencer #(
    parameter int KW      = 8,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [KW-1:0] job_k,
    input  logic          job_e5m2,
    input  logic          job_czero,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    output logic          tc_e5m2mode,
    output logic          tc_in_valid,
    output logic [255:0]  tc_a,
    output logic [255:0]  tc_b,
    output logic [255:0]  tc_c,
    input  logic [255:0]  tc_d,
    input  logic          tc_out_valid,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          out_last,
    output logic          busy,
    output logic          err_timeout
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_C, LOAD_A, LOAD_B, ISSUE, WAIT, DRAIN} state_t;

    state_t         state;
    state_t         state_next;
    logic [KW-1:0]  k_left;
    logic [1:0]     beat;
    logic [255:0]   acc;
    logic [TW-1:0]  timer;
    logic           wait_expired;

    assign wait_expired = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        job_ready   = 1'b0;
        in_ready    = 1'b0;
        tc_in_valid = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) begin
                    if (job_k == '0 && job_czero) state_next = DRAIN;
                    else if (!job_czero)          state_next = LOAD_C;
                    else                          state_next = LOAD_A;
                end
            end
            LOAD_C: begin
                in_ready = 1'b1;
                if (in_valid && beat == 2'd3) state_next = (k_left == '0) ? DRAIN : LOAD_A;
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && beat == 2'd3) state_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && beat == 2'd3) state_next = ISSUE;
            end
            ISSUE: begin
                tc_in_valid = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                // A response arriving on the last permitted cycle still counts as success.
                if (tc_out_valid)      state_next = (k_left == KW'(1)) ? DRAIN : LOAD_A;
                else if (wait_expired) state_next = IDLE;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = acc[{beat, 6'd0} +: 64];
                out_last  = (beat == 2'd3);
                if (out_ready && beat == 2'd3) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_left      <= '0;
            beat        <= '0;
            acc         <= '0;
            timer       <= '0;
            tc_a        <= '0;
            tc_b        <= '0;
            tc_c        <= '0;
            tc_e5m2mode <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (job_valid) begin
                        k_left      <= job_k;
                        tc_e5m2mode <= job_e5m2;
                        acc         <= '0;
                        beat        <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                LOAD_C: begin
                    if (in_valid) begin
                        acc[{beat, 6'd0} +: 64] <= in_data;
                        beat                    <= beat + 2'd1;
                    end
                end
                LOAD_A: begin
                    if (in_valid) begin
                        tc_a[{beat, 6'd0} +: 64] <= in_data;
                        beat                     <= beat + 2'd1;
                    end
                end
                LOAD_B: begin
                    if (in_valid) begin
                        tc_b[{beat, 6'd0} +: 64] <= in_data;
                        beat                     <= beat + 2'd1;
                        if (beat == 2'd3) tc_c <= acc;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    if (tc_out_valid) begin
                        acc    <= tc_d;
                        k_left <= k_left - KW'(1);
                    end else if (wait_expired) begin
                        err_timeout <= 1'b1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) beat <= beat + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_tile_sequencer.sv
// Randomized bench for tc_tile_sequencer: a job-level model predicts every tensorcore issue and
// every output beat, a bench-side tensorcore answers issues, and one monitor compares each cycle.
module tb_tc_tile_sequencer;

    localparam int KW      = 8;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic [KW-1:0] job_k;
    logic          job_e5m2;
    logic          job_czero;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          tc_e5m2mode;
    logic          tc_in_valid;
    logic [255:0]  tc_a, tc_b, tc_c, tc_d;
    logic          tc_out_valid;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic          out_last;
    logic          busy;
    logic          err_timeout;

    tc_tile_sequencer #(.KW(KW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_k(job_k),
        .job_e5m2(job_e5m2), .job_czero(job_czero),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tc_e5m2mode(tc_e5m2mode), .tc_in_valid(tc_in_valid),
        .tc_a(tc_a), .tc_b(tc_b), .tc_c(tc_c), .tc_d(tc_d), .tc_out_valid(tc_out_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_timeout(err_timeout)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] c;
        logic         e5m2;
    } issue_t;

    issue_t       exp_issue[$];
    logic [63:0]  exp_out[$];
    logic [63:0]  got_out[$];
    logic [63:0]  beat_q[$];
    logic [255:0] c_word;
    logic [255:0] a_words[16];
    logic [255:0] b_words[16];
    int           checks = 0;
    int           errors = 0;
    int           out_beat_idx = 0;
    int           issue_count = 0;
    bit           use_fixed_d = 1'b0;
    logic [255:0] fixed_d = '0;
    int           tc_latency = 0;
    bit           tc_silent = 1'b0;
    bit           manual_ready = 1'b0;

    task automatic checkOutput(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic bound_fail(input string name, input int waited);
        checks++;
        errors++;
        $display("[TB] FAIL %s waited=%0d cycles, required completion within bound", name, waited);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // The bench tensorcore's arithmetic: a plain 256-bit sum unless a fixed result is forced.
    function automatic logic [255:0] tc_func(input logic [255:0] a, input logic [255:0] b, input logic [255:0] c);
        return use_fixed_d ? fixed_d : (a + b + c);
    endfunction

    // Job-level model: beat stream to feed, issues the tensorcore must see, tile beats to expect.
    task automatic build_job(input int k, input bit czero, input bit e5m2, input bit silent);
        logic [255:0] acc;
        issue_t       it;
        acc = czero ? '0 : c_word;
        if (!czero) for (int i = 0; i < 4; i++) beat_q.push_back(c_word[i*64 +: 64]);
        for (int s = 0; s < k; s++) begin
            for (int i = 0; i < 4; i++) beat_q.push_back(a_words[s][i*64 +: 64]);
            for (int i = 0; i < 4; i++) beat_q.push_back(b_words[s][i*64 +: 64]);
            it.a = a_words[s]; it.b = b_words[s]; it.c = acc; it.e5m2 = e5m2;
            exp_issue.push_back(it);
            acc = tc_func(a_words[s], b_words[s], acc);
            if (silent) return;
        end
        for (int i = 0; i < 4; i++) exp_out.push_back(acc[i*64 +: 64]);
    endtask

    task automatic applyStimulus(input int k, input bit e5m2, input bit czero);
        bit fire = 1'b0;
        int cycles = 0;
        job_valid = 1'b1; job_k = KW'(k); job_e5m2 = e5m2; job_czero = czero;
        while (!fire) begin
            @(negedge clk);
            fire = job_ready;
            @(posedge clk); #1;
            if (++cycles > 500) begin bound_fail("jobAccept", cycles); break; end
        end
        job_valid = 1'b0; job_k = KW'($urandom); job_e5m2 = 1'($urandom); job_czero = 1'($urandom);
    endtask

    task automatic feed_beats(input int limit);
        int fed = 0;
        int cycles = 0;
        bit fire;
        while (beat_q.size() > 0 && fed < limit) begin
            if (cycles > 3000) begin bound_fail("feedBeats", cycles); beat_q.delete(); break; end
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = beat_q[0];
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) begin void'(beat_q.pop_front()); fed++; end
            cycles++;
        end
        in_valid = 1'b0;
        in_data  = 64'($urandom);
    endtask

    task automatic wait_idle();
        int cycles = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!busy && exp_out.size() == 0) done = 1'b1;
            else if (cycles > 3000) begin
                bound_fail("waitIdle", cycles);
                exp_out.delete();
                done = 1'b1;
            end
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("issuesConsumed", 256'(exp_issue.size()), 256'd0);
        exp_issue.delete();
    endtask

    task automatic random_words();
        c_word = rand256();
        for (int s = 0; s < 16; s++) begin a_words[s] = rand256(); b_words[s] = rand256(); end
    endtask

    task automatic run_job(input int k, input bit e5m2, input bit czero);
        build_job(k, czero, e5m2, 1'b0);
        applyStimulus(k, e5m2, czero);
        feed_beats(1 << 20);
        wait_idle();
    endtask

    // Monitor: every cycle, compare issues and output beats against the model's queues.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("jobReadyIsIdle", 256'(job_ready), 256'(!busy));
            if (in_ready && out_valid) checkOutput("loadDrainExclusive", 256'(in_ready), 256'd0);
            if (tc_in_valid) begin
                issue_count++;
                if (exp_issue.size() == 0) begin
                    checkOutput("unexpectedIssue", 256'(tc_in_valid), 256'd0);
                end else begin
                    checkOutput("issueA", tc_a, exp_issue[0].a);
                    checkOutput("issueB", tc_b, exp_issue[0].b);
                    checkOutput("issueC", tc_c, exp_issue[0].c);
                    checkOutput("issueE5m2", 256'(tc_e5m2mode), 256'(exp_issue[0].e5m2));
                    void'(exp_issue.pop_front());
                end
            end
            if (out_valid) begin
                if (exp_out.size() == 0) begin
                    checkOutput("unexpectedOut", 256'(out_valid), 256'd0);
                end else begin
                    checkOutput("outData", 256'(out_data), 256'(exp_out[0]));
                    checkOutput("outLast", 256'(out_last), 256'(out_beat_idx == 3));
                    if (out_ready) begin
                        got_out.push_back(out_data);
                        void'(exp_out.pop_front());
                        out_beat_idx = (out_beat_idx + 1) % 4;
                    end
                end
            end
        end
    end

    // Bench tensorcore: answers each issue after a latency; stray result pulses only outside WAIT.
    initial begin
        logic [255:0] resp_d;
        int           lat;
        tc_out_valid = 1'b0;
        tc_d         = '0;
        forever begin
            @(negedge clk);
            if (rst && tc_in_valid) begin
                tc_out_valid = 1'b0;
                resp_d = tc_func(tc_a, tc_b, tc_c);
                if (tc_silent) begin
                    repeat (TIMEOUT + 2) @(posedge clk);
                end else begin
                    lat = (tc_latency == 0) ? $urandom_range(1, 8) : tc_latency;
                    repeat (lat) @(posedge clk);
                    #1;
                    tc_out_valid = 1'b1;
                    tc_d         = resp_d;
                    @(posedge clk); #1;
                    tc_out_valid = 1'b0;
                end
            end else begin
                tc_out_valid = ($urandom_range(0, 7) == 0);
                tc_d         = rand256();
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!manual_ready) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time exceeded limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0]  pins[4];
        logic [63:0]  exp_beat1;
        int           issues_before;
        rst = 1'b0; job_valid = 1'b0; job_k = '0; job_e5m2 = 1'b0; job_czero = 1'b0;
        in_valid = 1'b0; in_data = '0;

        #3;
        checkOutput("resetBusy", 256'(busy), 256'd0);
        checkOutput("resetOutValid", 256'(out_valid), 256'd0);
        checkOutput("resetTcInValid", 256'(tc_in_valid), 256'd0);
        checkOutput("resetOutData", 256'(out_data), 256'd0);
        checkOutput("resetErr", 256'(err_timeout), 256'd0);
        checkOutput("resetTcA", tc_a, 256'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("releaseJobReady", 256'(job_ready), 256'd1);
        @(posedge clk); #1;

        // Reset mid LOAD_B drops the job.
        random_words();
        build_job(2, 1'b0, 1'b1, 1'b0);
        applyStimulus(2, 1'b1, 1'b0);
        feed_beats(10);
        #2 rst = 1'b0;
        #1;
        checkOutput("midResetBusy", 256'(busy), 256'd0);
        checkOutput("midResetTcInValid", 256'(tc_in_valid), 256'd0);
        checkOutput("midResetOutValid", 256'(out_valid), 256'd0);
        checkOutput("midResetTcB", tc_b, 256'd0);
        beat_q.delete(); exp_issue.delete(); exp_out.delete(); out_beat_idx = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midResetJobReady", 256'(job_ready), 256'd1);
        @(posedge clk); #1;

        // Single step, C zero, tensorcore returns a fixed pattern after 5 cycles.
        for (int i = 0; i < 4; i++) begin
            a_words[0][i*64 +: 64] = 64'h1111111111111111;
            b_words[0][i*64 +: 64] = 64'h2222222222222222;
        end
        use_fixed_d = 1'b1; fixed_d = {32{8'hAB}}; tc_latency = 5;
        got_out.delete(); issues_before = issue_count;
        run_job(1, 1'b0, 1'b1);
        checkOutput("k1IssueCount", 256'(issue_count - issues_before), 256'd1);
        checkOutput("k1BeatCount", 256'(got_out.size()), 256'd4);
        for (int i = 0; i < 4 && i < got_out.size(); i++) checkOutput("k1Beat", 256'(got_out[i]), 256'(64'hABABABABABABABAB));
        use_fixed_d = 1'b0; tc_latency = 0;

        // Three steps with C loaded; D chain feeds back as C.
        for (int s = 0; s < 3; s++) for (int i = 0; i < 4; i++) begin
            a_words[s][i*64 +: 64] = 64'h1111111111111111;
            b_words[s][i*64 +: 64] = 64'h2222222222222222;
        end
        for (int i = 0; i < 4; i++) c_word[i*64 +: 64] = 64'h0102030405060708;
        got_out.delete(); issues_before = issue_count;
        run_job(3, 1'b1, 1'b0);
        checkOutput("k3IssueCount", 256'(issue_count - issues_before), 256'd3);
        checkOutput("k3BeatCount", 256'(got_out.size()), 256'd4);
        for (int i = 0; i < 4 && i < got_out.size(); i++) checkOutput("k3Beat", 256'(got_out[i]), 256'(64'h9A9B9C9D9E9FA0A1));

        // k=0 with C: output equals the C beats, no issue.
        pins[0] = 64'hDEADDEADDEADDEAD; pins[1] = 64'hBEEFBEEFBEEFBEEF;
        pins[2] = 64'hCAFECAFECAFECAFE; pins[3] = 64'hF00DF00DF00DF00D;
        for (int i = 0; i < 4; i++) c_word[i*64 +: 64] = pins[i];
        got_out.delete(); issues_before = issue_count;
        run_job(0, 1'b0, 1'b0);
        checkOutput("k0IssueCount", 256'(issue_count - issues_before), 256'd0);
        checkOutput("k0BeatCount", 256'(got_out.size()), 256'd4);
        for (int i = 0; i < 4 && i < got_out.size(); i++) checkOutput("k0Beat", 256'(got_out[i]), 256'(pins[i]));

        // Output stall on beat 1 holds data and last.
        random_words();
        manual_ready = 1'b1; out_ready = 1'b0;
        build_job(1, 1'b1, 1'b0, 1'b0);
        exp_beat1 = exp_out[1];
        applyStimulus(1, 1'b0, 1'b1);
        feed_beats(1 << 20);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid) break;
            if (c == 199) bound_fail("stallWaitDrain", c);
            @(posedge clk); #1;
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stallValid", 256'(out_valid), 256'd1);
            checkOutput("stallData", 256'(out_data), 256'(exp_beat1));
            checkOutput("stallLast", 256'(out_last), 256'd0);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        wait_idle();
        manual_ready = 1'b0;

        // Response on the last permitted WAIT cycle wins over the timeout.
        random_words();
        tc_latency = TIMEOUT;
        run_job(1, 1'b1, 1'b0);
        checkOutput("lateResponseNoErr", 256'(err_timeout), 256'd0);
        tc_latency = 0;

        // Silent tensorcore: timeout after exactly TIMEOUT WAIT cycles, no output beats.
        random_words();
        tc_silent = 1'b1;
        build_job(2, 1'b1, 1'b0, 1'b1);
        applyStimulus(2, 1'b0, 1'b1);
        feed_beats(8);
        @(negedge clk);
        checkOutput("timeoutIssue", 256'(tc_in_valid), 256'd1);
        repeat (TIMEOUT) begin
            @(negedge clk);
            checkOutput("timeoutWaitBusy", 256'(busy), 256'd1);
            checkOutput("timeoutWaitErr", 256'(err_timeout), 256'd0);
        end
        @(negedge clk);
        checkOutput("timeoutErrSet", 256'(err_timeout), 256'd1);
        checkOutput("timeoutIdle", 256'(busy), 256'd0);
        checkOutput("timeoutNoOut", 256'(out_valid), 256'd0);
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        tc_silent = 1'b0;
        checkOutput("timeoutErrSticky", 256'(err_timeout), 256'd1);
        build_job(0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("acceptClearsErr", 256'(err_timeout), 256'd0);
        wait_idle();

        // Randomized jobs.
        for (int j = 0; j < 14; j++) begin
            random_words();
            run_job($urandom_range(0, 4), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
